dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the riscv core's load/store port; it services one access at a time over a valid/ready request channel and a valid/ready response channel.
- It replaces the zero-latency behavioural memory in single-cycle benches with a synthesizable memory that has a parameterised, deterministic access latency and byte-enabled writes.
- It will also serve as the data memory for the planned multi-cycle and pipelined cores.

Parameters:
- DEPTH, 32: number of 32-bit words. Power of two, at least 2.
- LATENCY, 1: cycles from the accept edge to the response edge. Range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i covers bits [8i+7:8i]. Ignored on loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errored accesses.
- rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to IDLE; req_ready=0 during reset; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory is reinitialised: word0=32'hffffff00, word1=32'hffff0000, all other words 0.
  - Any pending request is dropped; a store that has not reached its commit edge is never written.
- State machine (IDLE, BUSY, RESP):
  - IDLE: req_ready=1. On an edge with req_valid && req_ready (the accept edge, E0), capture req_we, req_addr, req_wdata and req_be, load cnt=LATENCY-1, and move to BUSY.
  - BUSY: req_ready=0, rsp_valid=0. At each edge, if cnt!=0 then decrement cnt; otherwise perform the access and move to RESP. The access therefore completes at edge E_LATENCY, and rsp_valid is first high in the cycle after E_LATENCY.
  - RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable. On an edge with rsp_ready=1, move to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0. If rsp_ready=0, the response is held indefinitely.
  - req_valid is ignored in BUSY and RESP; the requester must hold its request until it sees req_ready.
- Access rules at the commit edge:
  - Word index = req_addr[31:2].
  - Error if req_addr[1:0]!=0 or the word index >= DEPTH. On error: memory is unchanged, rsp_err=1, rsp_rdata=0.
  - Load: rsp_rdata = mem[index], the value before any write at that same edge (none is possible, since only one access is outstanding).
  - Store: for each i with req_be[i]=1, mem[index] byte i = req_wdata byte i; other bytes are unchanged. req_be=0 is a legal no-op store that is still acknowledged. rsp_rdata=0.
- Throughput:
  - At most one outstanding access.
  - Minimum request spacing is LATENCY+2 cycles: the accept edge, LATENCY edges to commit, and one response-handshake edge, after which IDLE restores req_ready.
- Reset asserted mid-operation takes priority over every other transition. A response held in RESP is discarded, and rsp_valid is 0 in the cycle after the reset edge.
- Memory is a plain register array. No read-during-write hazards exist, because accesses are serialised.

Test Plan:
- Reset then load: release reset; load addr 0x0 (LATENCY=1) -> accepted at E0, rsp_valid high after E1, rsp_rdata=32'hffffff00, rsp_err=0; load 0x4 -> 32'hffff0000.
- Byte-enabled store then load: store addr 0x8, wdata 32'h12345678, be=4'b0101 -> response with rsp_rdata=0, rsp_err=0; load 0x8 -> 32'h00340078.
- Error cases: load 0x2 -> rsp_err=1, rsp_rdata=0. Store 0x80 (index 32 >= DEPTH) with be=4'hf, wdata 32'hdeadbeef -> rsp_err=1; then load 0x0 -> still 32'hffffff00, with no aliasing.
- Latency and backpressure: LATENCY=4, load 0x4 with rsp_ready=0 for 3 cycles -> rsp_valid rises exactly 4 edges after accept, and rsp_rdata stays stable while held. req_ready=0 throughout BUSY and RESP, and returns to 1 the cycle after the rsp_ready handshake.
- Reset mid-operation: LATENCY=4, store 0xC = 32'hcafef00d with be=4'hf, then assert reset 2 cycles after accept -> no response is produced; after release, load 0xC -> 0.
- Back-to-back loads with req_valid held high and rsp_ready=1 -> accept edges are spaced exactly LATENCY+2 cycles apart, and every response carries the correct data.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Data-memory responder with fixed access latency and byte-enabled stores
//
// Services one load/store at a time. A request is accepted in IDLE, held for
// LATENCY edges (the last of which commits the access), then the response is
// presented until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (IDLE only, low while reset is held)
//   req_we     1 = store, 0 = load
//   req_addr   byte address (word index = req_addr[31:2])
//   req_wdata  store data
//   req_be     store byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  consumer accepts the response
//   rsp_rdata  load data; 0 for stores and errored accesses
//   rsp_err    access was misaligned or out of range
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_commit;
  logic        w_rsp_done;

  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic [29:0]   w_word_idx;
  logic [AW-1:0] w_mem_idx;
  logic          w_misaligned;
  logic          w_oob;
  logic          w_access_err;

  // Address decode works on the captured request, so it is stable from the
  // accept edge until the commit edge.
  assign w_word_idx   = r_addr[31:2];
  assign w_mem_idx    = w_word_idx[AW-1:0];
  assign w_misaligned = (r_addr[1:0] != 2'b00);
  assign w_oob        = ({2'b00, w_word_idx} >= 32'(DEPTH));
  assign w_access_err = w_misaligned || w_oob;

  assign req_ready = reset && (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and storage. Reset reloads the memory image, so a store that was
  // accepted but had not yet committed simply disappears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (i == 0) ? 32'hffffff00 :
                    (i == 1) ? 32'hffff0000 : 32'h00000000;
      end
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= CNT_INIT;
      end

      if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_commit) begin
        if (w_access_err) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b1;
        end else if (r_we) begin
          for (int b = 0; b < 4; b++) begin
            if (r_be[b]) begin
              r_mem[w_mem_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
        end else begin
          r_rdata <= r_mem[w_mem_idx];
          r_err   <= 1'b0;
        end
      end

      if (w_rsp_done) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Self-checking bench for dmem_responder at LATENCY 1 and 4
module tb_dmem_responder;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m_mem [2][DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        m_mem[d][i] = (i == 0) ? 32'hffffff00 : (i == 1) ? 32'hffff0000 : 32'h0;
  endtask

  task automatic model_access(input int d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output logic [31:0] rdata, output logic err);
    int unsigned idx;
    logic [31:0] mask;
    idx   = addr / 4;
    err   = ((addr % 4) != 0) || (idx >= DEPTH);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        mask = 32'h0;
        for (int b = 0; b < 4; b++)
          if (be[b]) mask = mask | (32'hff << (8 * b));
        m_mem[d][idx] = (m_mem[d][idx] & ~mask) | (wdata & mask);
      end else begin
        rdata = m_mem[d][idx];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, DEPTH + 3)) << 2;
    if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic do_access(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int hold, input string tag,
                           output logic [31:0] obs_rdata, output logic obs_err);
    logic [31:0] exp_rd, held;
    logic        exp_err;
    int          k;
    obs_rdata = 32'hx;
    obs_err   = 1'bx;
    @(negedge clk);
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b0;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_checks++;
    if (req_ready[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s accept: req_ready=%b required 1 within 50 cycles", tag, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    model_access(d, we, addr, wdata, be, exp_rd, exp_err);
    @(negedge clk);
    req_valid[d] = 1'b0;
    k = 0;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      n_checks++;
      if (req_ready[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL %s busy_ready: req_ready=%b required 0", tag, req_ready[d]);
      end
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != lat_of(d)) begin
      n_errors++;
      $display("FAIL %s latency: got %0d edges, required %0d", tag, k, lat_of(d));
    end
    obs_rdata = rsp_rdata[d];
    obs_err   = rsp_err[d];
    held      = rsp_rdata[d];
    n_checks++;
    if (rsp_rdata[d] !== exp_rd || rsp_err[d] !== exp_err) begin
      n_errors++;
      $display("FAIL %s response: rdata=%h err=%b required rdata=%h err=%b",
               tag, rsp_rdata[d], rsp_err[d], exp_rd, exp_err);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== held || req_ready[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL %s hold: valid=%b rdata=%h ready=%b required valid=1 rdata=%h ready=0",
                 tag, rsp_valid[d], rsp_rdata[d], req_ready[d], held);
      end
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    n_checks++;
    if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0 ||
        req_ready[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s release: valid=%b rdata=%h err=%b ready=%b required 0 0 0 1",
               tag, rsp_valid[d], rsp_rdata[d], rsp_err[d], req_ready[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 ||
          rsp_err[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_release[%0d]: req_ready=%b required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_init_loads();
    logic [31:0] rd;
    logic        er;
    do_access(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, "load0", rd, er);
    n_checks++;
    if (rd !== 32'hffffff00) begin
      n_errors++;
      $display("FAIL init_word0: rdata=%h required ffffff00", rd);
    end
    do_access(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, "load4", rd, er);
    n_checks++;
    if (rd !== 32'hffff0000) begin
      n_errors++;
      $display("FAIL init_word1: rdata=%h required ffff0000", rd);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd;
    logic        er;
    do_access(0, 1'b1, 32'h8, 32'h12345678, 4'b0101, 0, "store8", rd, er);
    do_access(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, "load8", rd, er);
    n_checks++;
    if (rd !== 32'h00340078) begin
      n_errors++;
      $display("FAIL byte_store: rdata=%h required 00340078", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    do_access(0, 1'b0, 32'h2, 32'h0, 4'h0, 0, "misaligned", rd, er);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_errors++;
      $display("FAIL misaligned: err=%b rdata=%h required err=1 rdata=0", er, rd);
    end
    do_access(0, 1'b1, 32'h80, 32'hdeadbeef, 4'hf, 0, "oob_store", rd, er);
    n_checks++;
    if (er !== 1'b1) begin
      n_errors++;
      $display("FAIL oob_store: err=%b required 1", er);
    end
    do_access(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, "alias_check", rd, er);
    n_checks++;
    if (rd !== 32'hffffff00 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL no_alias: rdata=%h err=%b required ffffff00 0", rd, er);
    end
  endtask

  task automatic test_latency_backpressure();
    logic [31:0] rd;
    logic        er;
    do_access(1, 1'b0, 32'h4, 32'h0, 4'h0, 3, "lat4_hold", rd, er);
    n_checks++;
    if (rd !== 32'hffff0000) begin
      n_errors++;
      $display("FAIL lat4_data: rdata=%h required ffff0000", rd);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    logic        er;
    int          k;
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[1] = 32'hc; req_wdata[1] = 32'hcafef00d; req_be[1] = 4'hf;
    req_valid[1] = 1'b1;
    k = 0;
    while (req_ready[1] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_state[%0d]: valid=%b ready=%b required 0 0",
                 d, rsp_valid[d], req_ready[d]);
      end
    end
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid[1] !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_no_rsp: rsp_valid=%b required 0 at cycle %0d", rsp_valid[1], c);
      end
    end
    do_access(1, 1'b0, 32'hc, 32'h0, 4'h0, 0, "midreset_load", rd, er);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_dropped_store: rdata=%h required 0", rd);
    end
  endtask

  task automatic test_back_to_back(input int d, input int n);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          prev, k;
    prev = -1;
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    req_we[d] = 1'b0; req_addr[d] = rand_addr(); req_valid[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (req_ready[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      if (prev >= 0) begin
        n_checks++;
        if (cyc - prev != lat_of(d) + 2) begin
          n_errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d", d, cyc - prev, lat_of(d) + 2);
        end
      end
      prev = cyc;
      model_access(d, 1'b0, req_addr[d], 32'h0, 4'h0, exp_rd, exp_err);
      @(negedge clk);
      if (i == n - 1) req_valid[d] = 1'b0;
      else req_addr[d] = rand_addr();
      k = 0;
      while (rsp_valid[d] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      n_checks++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== exp_rd || rsp_err[d] !== exp_err) begin
        n_errors++;
        $display("FAIL b2b_data[%0d]: valid=%b rdata=%h err=%b required 1 %h %b",
                 d, rsp_valid[d], rsp_rdata[d], rsp_err[d], exp_rd, exp_err);
      end
    end
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd;
    logic        er;
    int          d;
    for (int i = 0; i < n; i++) begin
      d = int'($urandom_range(0, 1));
      do_access(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), "random", rd, er);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_loads();
    test_byte_store();
    test_errors();
    test_latency_backpressure();
    test_reset_mid_op();
    test_back_to_back(0, 8);
    test_back_to_back(1, 8);
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
